// File: rtl/encode_scheduler_if.sv
// Encoder-side bundle of the band scheduler: band control inputs, page/MCU/ereq
// outputs to the three component encoders, packer tag and status.
// Handshake: ereq_* is a window strobe, not a valid/ready pair. The scheduler
// opens a window (exactly one ereq_* high for DCT_TH+1 cycles) only after
// pk_ready was sampled high on the last setup cycle. Once a window is open,
// no input can shorten or stall it.
interface encode_scheduler_if;
  logic [7:0] h_mcu;
  logic       band_done;
  logic       vsync;
  logic       pk_ready;
  logic       page;
  logic [7:0] e_x_mcu;
  logic       ereq_y;
  logic       ereq_cb;
  logic       ereq_cr;
  logic [1:0] comp_o;
  logic       busy;
  logic       band_end;
  logic       overrun;
  logic [2:0] state;

  modport master (
    input  h_mcu, band_done, vsync, pk_ready,
    output page, e_x_mcu, ereq_y, ereq_cb, ereq_cr, comp_o,
           busy, band_end, overrun, state
  );

  modport slave (
    output h_mcu, band_done, vsync, pk_ready,
    input  page, e_x_mcu, ereq_y, ereq_cb, ereq_cr, comp_o,
           busy, band_end, overrun, state
  );
endinterface

// File: rtl/encode_scheduler.sv
// Band scheduler for the Y/Cb/Cr encoders. Flips the shared capture/encode page
// on each band, then walks MCU 0..h_mcu-1 issuing one ereq window per component,
// drains the encoder pipeline and signals band_end. The current FSM state is
// exported on bus.state.
module encode_scheduler #(
  parameter int         DCT_TH  = 28,
  parameter int         SETUP   = 2,
  parameter int         ENC_LAT = 6,
  parameter logic [7:0] X_BASE  = 8'd0
) (
  input logic                clk,
  input logic                rst_n,
  encode_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_REQ   = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4,
    S_END   = 3'd5
  } state_t;

  localparam logic [1:0] C_Y  = 2'd0;
  localparam logic [1:0] C_CB = 2'd1;
  localparam logic [1:0] C_CR = 2'd2;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);
  localparam logic [7:0] REQ_LAST   = 8'(DCT_TH);
  localparam logic [7:0] DRAIN_LAST = 8'(ENC_LAT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] h_lat;
  logic [7:0] mcu;
  logic [1:0] comp;
  logic       stop;
  logic       page;
  logic [7:0] e_x_mcu;
  logic       ereq_y, ereq_cb, ereq_cr;
  logic       busy;
  logic       band_end;
  logic       overrun;
  logic [1:0] comp_pipe [ENC_LAT+1];

  // Main sequencer: page ownership, window timing, component/MCU walk, drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      h_lat    <= 8'd0;
      mcu      <= 8'd0;
      comp     <= C_Y;
      stop     <= 1'b0;
      page     <= 1'b0;
      e_x_mcu  <= X_BASE;
      ereq_y   <= 1'b0;
      ereq_cb  <= 1'b0;
      ereq_cr  <= 1'b0;
      busy     <= 1'b0;
      band_end <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      band_end <= 1'b0;
      // vsync clears first; a band_done that collides with a busy band re-sets.
      if (bus.band_done && state != S_IDLE) overrun <= 1'b1;
      else if (bus.vsync)                   overrun <= 1'b0;
      // vsync mid-band: finish the current window and its gap, then drain.
      if (bus.vsync && state != S_IDLE) stop <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.band_done) begin
            page    <= ~page;
            e_x_mcu <= X_BASE;
            comp    <= C_Y;
            mcu     <= 8'd0;
            h_lat   <= bus.h_mcu;
            cnt     <= 8'd0;
            stop    <= 1'b0;
            busy    <= 1'b1;
            state   <= (bus.h_mcu == 8'd0) ? S_DRAIN : S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            if (bus.pk_ready) begin
              cnt     <= 8'd0;
              ereq_y  <= (comp == C_Y);
              ereq_cb <= (comp == C_CB);
              ereq_cr <= (comp == C_CR);
              state   <= S_REQ;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_REQ: begin
          if (cnt == REQ_LAST) begin
            cnt     <= 8'd0;
            ereq_y  <= 1'b0;
            ereq_cb <= 1'b0;
            ereq_cr <= 1'b0;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_GAP: begin
          cnt <= 8'd0;
          if (comp == C_CR) begin
            comp    <= C_Y;
            e_x_mcu <= e_x_mcu + 8'd1;
            mcu     <= mcu + 8'd1;
          end else begin
            comp <= comp + 2'd1;
          end
          if ((comp == C_CR && mcu == h_lat - 8'd1) || stop || bus.vsync)
            state <= S_DRAIN;
          else
            state <= S_SETUP;
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt      <= 8'd0;
            band_end <= 1'b1;
            state    <= S_END;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_END: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Component tag follows the encoder latency so it lines up with elen/edata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ENC_LAT; i++) comp_pipe[i] <= C_Y;
    end else begin
      comp_pipe[0] <= comp;
      for (int i = 1; i <= ENC_LAT; i++) comp_pipe[i] <= comp_pipe[i-1];
    end
  end

  assign bus.page     = page;
  assign bus.e_x_mcu  = e_x_mcu;
  assign bus.ereq_y   = ereq_y;
  assign bus.ereq_cb  = ereq_cb;
  assign bus.ereq_cr  = ereq_cr;
  assign bus.comp_o   = comp_pipe[ENC_LAT];
  assign bus.busy     = busy;
  assign bus.band_end = band_end;
  assign bus.overrun  = overrun;
  assign bus.state    = state;

endmodule

// File: tb/tb_encode_scheduler.sv
// Directed bench for encode_scheduler. Each ereq window and band_end pulse is
// predicted when the band is started and checked by a negedge monitor.
module tb_encode_scheduler;

  localparam int W = 34;  // {comp[1:0], x_mcu[7:0], start_cycle[15:0], width[7:0]}

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_page = 0;

  logic [W-1:0] exp_q[$];
  int           end_q[$];

  encode_scheduler_if bus ();

  encode_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and cycle label: after posedge k the design is in cycle k.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push_win(input int comp, input int x, input int start, input int width);
    exp_q.push_back({2'(comp), 8'(x), 16'(start), 8'(width)});
  endtask

  // Drive band_done for one cycle; optionally predict a full unstalled band.
  task automatic start_band(input int h, input bit predict, output int t0);
    bus.h_mcu     = 8'(h);
    bus.band_done = 1'b1;
    t0 = cyc;
    exp_page ^= 1;
    if (predict) begin
      for (int i = 0; i < 3 * h; i++) push_win(i % 3, i / 3, t0 + 3 + 32 * i, 29);
      end_q.push_back(t0 + 96 * h + 7);
    end
    tick();
    bus.band_done = 1'b0;
  endtask

  // Monitor: reconstruct ereq windows and band_end pulses, compare with predictions.
  logic [2:0] ereq_v;
  logic [2:0] ereq_prev = 3'b000;
  int         rise_cyc = 0;
  logic [1:0] rise_comp = 2'd0;
  logic [7:0] rise_x = 8'd0;
  int         multi = 0;
  int         x_moved = 0;
  logic [W-1:0] obs_w;

  always @(negedge clk) begin
    ereq_v = {bus.ereq_cr, bus.ereq_cb, bus.ereq_y};
    if (ereq_v != 3'b000 && ereq_prev == 3'b000) begin
      rise_cyc  = cyc;
      rise_comp = ereq_v[0] ? 2'd0 : (ereq_v[1] ? 2'd1 : 2'd2);
      rise_x    = bus.e_x_mcu;
      multi     = 0;
      x_moved   = 0;
    end
    if (ereq_v != 3'b000) begin
      if ($countones(ereq_v) > 1) multi++;
      if (bus.e_x_mcu != rise_x) x_moved++;
      if (cyc == rise_cyc + 7) check("comp_o_tag", 64'(bus.comp_o), 64'(rise_comp));
    end
    if (ereq_v == 3'b000 && ereq_prev != 3'b000) begin
      obs_w = {rise_comp, rise_x, 16'(rise_cyc), 8'(cyc - rise_cyc)};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_window: observed %0h expected none", obs_w);
      end else begin
        check("window", 64'(obs_w), 64'(exp_q.pop_front()));
      end
      check("ereq_onehot", 64'(multi), 64'd0);
      check("x_stable", 64'(x_moved), 64'd0);
    end
    if (bus.band_end) begin
      if (end_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_band_end: observed cycle %0d expected none", cyc);
      end else begin
        check("band_end_cycle", 64'(cyc), 64'(end_q.pop_front()));
      end
    end
    ereq_prev = ereq_v;
  end

  initial begin
    int t0;
    rst_n         = 1'b0;
    bus.h_mcu     = 8'd0;
    bus.band_done = 1'b0;
    bus.vsync     = 1'b0;
    bus.pk_ready  = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_page", 64'(bus.page), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ereq", 64'({bus.ereq_y, bus.ereq_cb, bus.ereq_cr}), 64'd0);
    check("rst_x", 64'(bus.e_x_mcu), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    check("rst_comp_o", 64'(bus.comp_o), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // T1: two-MCU band, packer always ready
    start_band(2, 1'b1, t0);
    check("t1_page", 64'(bus.page), 64'(exp_page));
    check("t1_busy", 64'(bus.busy), 64'd1);
    wait_until(t0 + 199);
    check("t1_band_end", 64'(bus.band_end), 64'd1);
    tick();
    check("t1_busy_after", 64'(bus.busy), 64'd0);
    check("t1_band_end_low", 64'(bus.band_end), 64'd0);
    check("t1_windows_left", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();

    // T2: packer stall during Cb setup delays the Cb window by 10 cycles
    start_band(1, 1'b0, t0);
    push_win(0, 0, t0 + 3, 29);
    push_win(1, 0, t0 + 45, 29);
    push_win(2, 0, t0 + 77, 29);
    end_q.push_back(t0 + 113);
    wait_until(t0 + 34);
    bus.pk_ready = 1'b0;
    wait_until(t0 + 40);
    check("t2_stall_ereq", 64'({bus.ereq_y, bus.ereq_cb, bus.ereq_cr}), 64'd0);
    check("t2_stall_x", 64'(bus.e_x_mcu), 64'd0);
    wait_until(t0 + 44);
    bus.pk_ready = 1'b1;
    wait_until(t0 + 114);
    check("t2_busy_after", 64'(bus.busy), 64'd0);
    check("t2_windows_left", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();

    // T3: band_done while busy sets overrun, band runs on, vsync clears
    start_band(2, 1'b1, t0);
    wait_until(t0 + 50);
    bus.band_done = 1'b1;
    tick();
    bus.band_done = 1'b0;
    check("t3_overrun", 64'(bus.overrun), 64'd1);
    check("t3_page_kept", 64'(bus.page), 64'(exp_page));
    wait_until(t0 + 200);
    check("t3_busy_after", 64'(bus.busy), 64'd0);
    check("t3_windows_left", 64'(exp_q.size()), 64'd0);
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
    check("t3_overrun_clr", 64'(bus.overrun), 64'd0);
    repeat (3) tick();

    // T4: vsync in the Cb window lets it finish, then drains
    start_band(2, 1'b0, t0);
    push_win(0, 0, t0 + 3, 29);
    push_win(1, 0, t0 + 35, 29);
    end_q.push_back(t0 + 71);
    wait_until(t0 + 40);
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
    wait_until(t0 + 72);
    check("t4_busy_after", 64'(bus.busy), 64'd0);
    check("t4_overrun", 64'(bus.overrun), 64'd0);
    repeat (40) tick();
    check("t4_windows_left", 64'(exp_q.size()), 64'd0);
    check("t4_ends_left", 64'(end_q.size()), 64'd0);

    // T5: asynchronous reset mid-window, then a clean restart at MCU 0
    start_band(2, 1'b0, t0);
    push_win(0, 0, t0 + 3, 17);
    wait_until(t0 + 20);
    rst_n = 1'b0;
    #1;
    exp_page = 0;
    check("t5_ereq_async", 64'(bus.ereq_y), 64'd0);
    check("t5_page_async", 64'(bus.page), 64'd0);
    check("t5_busy_async", 64'(bus.busy), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("t5_windows_left", 64'(exp_q.size()), 64'd0);
    start_band(1, 1'b1, t0);
    check("t5_page_restart", 64'(bus.page), 64'(exp_page));
    wait_until(t0 + 104);
    check("t5_busy_after", 64'(bus.busy), 64'd0);
    check("t5_restart_left", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();

    // T6: empty band, then band_done during the band_end cycle
    start_band(0, 1'b1, t0);
    check("t6_page", 64'(bus.page), 64'(exp_page));
    check("t6_busy", 64'(bus.busy), 64'd1);
    wait_until(t0 + 7);
    check("t6_band_end", 64'(bus.band_end), 64'd1);
    bus.band_done = 1'b1;
    tick();
    bus.band_done = 1'b0;
    check("t6_overrun", 64'(bus.overrun), 64'd1);
    check("t6_busy_after", 64'(bus.busy), 64'd0);
    check("t6_page_kept", 64'(bus.page), 64'(exp_page));
    repeat (3) tick();

    // T7: vsync and band_done together while idle: overrun clears, band starts
    bus.vsync = 1'b1;
    start_band(1, 1'b1, t0);
    bus.vsync = 1'b0;
    check("t7_overrun_clr", 64'(bus.overrun), 64'd0);
    check("t7_page", 64'(bus.page), 64'(exp_page));
    wait_until(t0 + 104);
    check("t7_busy_after", 64'(bus.busy), 64'd0);

    repeat (5) tick();
    check("final_windows_left", 64'(exp_q.size()), 64'd0);
    check("final_ends_left", 64'(end_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
